note_score_sequencer: RTL and testbench

//  Song-level controller for the per-note pitch comparator. Waits for a ref/sung frequency pair,

---
 rtl/note_score_sequencer_pkg.sv | 18 +
 rtl/note_score_accum.sv | 92 +++++++++
 rtl/note_score_sequencer.sv | 129 ++++++++++++
 tb/tb_note_score_sequencer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/note_score_sequencer_pkg.sv
// Shared definitions for the note score sequencer: FSM state encodings and comparator score levels.
package note_score_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_WAIT_PAIR  = 3'd1,
        S_ISSUE      = 3'd2,
        S_WAIT_SCORE = 3'd3,
        S_ACCUM      = 3'd4,
        S_DONE       = 3'd5
    } state_e;

    localparam logic [3:0] SCORE_FULL = 4'd10;
    localparam logic [3:0] SCORE_T1   = 4'd7;
    localparam logic [3:0] SCORE_T2   = 4'd5;
    localparam logic [3:0] SCORE_NONE = 4'd0;

endpackage

// File: rtl/note_score_accum.sv
// Song result accumulator: saturating total, perfect-note counter and (NOTE_SCORE_STREAK_EN) best streak.
module note_score_accum
    import note_score_sequencer_pkg::*;
#(
    parameter int NOTE_W = 8,
    parameter int TOT_W  = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              acc_en,
    input  logic [3:0]        score,
    output logic [TOT_W-1:0]  total,
    output logic [NOTE_W-1:0] perfect_count
`ifdef NOTE_SCORE_STREAK_EN
    ,
    output logic [NOTE_W-1:0] best_streak
`endif
);

    function automatic logic [TOT_W-1:0] sat_add(input logic [TOT_W-1:0] a, input logic [3:0] b);
        logic [TOT_W:0] s;
        s = {1'b0, a} + {{(TOT_W-3){1'b0}}, b};
        if (s[TOT_W]) return '1;
        return s[TOT_W-1:0];
    endfunction

    logic [TOT_W-1:0]  total_q, total_d;
    logic [NOTE_W-1:0] perfect_q, perfect_d;
    logic              is_full;

    assign is_full = (score == SCORE_FULL);

    always_comb begin
        total_d   = total_q;
        perfect_d = perfect_q;
        if (clr) begin
            total_d   = '0;
            perfect_d = '0;
        end else if (acc_en) begin
            total_d = sat_add(total_q, score);
            if (is_full) perfect_d = perfect_q + NOTE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            total_q   <= '0;
            perfect_q <= '0;
        end else begin
            total_q   <= total_d;
            perfect_q <= perfect_d;
        end
    end

    assign total         = total_q;
    assign perfect_count = perfect_q;

`ifdef NOTE_SCORE_STREAK_EN
    // A forced timeout score is 0, so it breaks the run like any other non-perfect note.
    logic [NOTE_W-1:0] cur_q, cur_d, best_q, best_d;

    always_comb begin
        cur_d  = cur_q;
        best_d = best_q;
        if (clr) begin
            cur_d  = '0;
            best_d = '0;
        end else if (acc_en) begin
            if (is_full) begin
                cur_d = cur_q + NOTE_W'(1);
                if (cur_d > best_q) best_d = cur_d;
            end else begin
                cur_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_q  <= '0;
            best_q <= '0;
        end else begin
            cur_q  <= cur_d;
            best_q <= best_d;
        end
    end

    assign best_streak = best_q;
`endif

endmodule

// File: rtl/note_score_sequencer.sv
// Song-level controller: issues one comparator request per note, watchdogs it, accumulates scores.
// Optional best-streak output enabled by defining NOTE_SCORE_STREAK_EN.
module note_score_sequencer
    import note_score_sequencer_pkg::*;
#(
    parameter int NOTE_W  = 8,
    parameter int TOT_W   = 12,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              song_start,
    input  logic [NOTE_W-1:0] song_len,
    input  logic              pair_avail,
    output logic              cmp_enable,
    output logic              cmp_start,
    input  logic              cmp_score_ready,
    input  logic [3:0]        cmp_score,
    output logic              busy,
    output logic              done,
    output logic [NOTE_W-1:0] notes_done,
    output logic [TOT_W-1:0]  total_score,
    output logic [NOTE_W-1:0] perfect_count,
    output logic              timeout_err
`ifdef NOTE_SCORE_STREAK_EN
    ,
    output logic [NOTE_W-1:0] best_streak
`endif
);

    localparam int WD_W = $clog2(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [NOTE_W-1:0] len_q, len_d;
    logic [NOTE_W-1:0] notes_q, notes_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic [3:0]        score_q, score_d;
    logic              terr_q, terr_d;
    logic              clr;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        notes_d = notes_q;
        wd_d    = wd_q;
        score_d = score_q;
        terr_d  = terr_q;
        clr     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (song_start) begin
                    clr     = 1'b1;
                    len_d   = song_len;
                    notes_d = '0;
                    terr_d  = 1'b0;
                    state_d = (song_len == '0) ? S_DONE : S_WAIT_PAIR;
                end
            end
            S_WAIT_PAIR: if (pair_avail) state_d = S_ISSUE;
            S_ISSUE: begin
                wd_d    = '0;
                state_d = S_WAIT_SCORE;
            end
            S_WAIT_SCORE: begin
                // A real strobe on the expiry cycle takes priority over the forced zero.
                if (cmp_score_ready) begin
                    score_d = cmp_score;
                    state_d = S_ACCUM;
                end else if (wd_q == WD_LAST) begin
                    score_d = SCORE_NONE;
                    terr_d  = 1'b1;
                    state_d = S_ACCUM;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            S_ACCUM: begin
                notes_d = notes_q + NOTE_W'(1);
                state_d = (notes_d == len_q) ? S_DONE : S_WAIT_PAIR;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            notes_q <= '0;
            wd_q    <= '0;
            score_q <= '0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            notes_q <= notes_d;
            wd_q    <= wd_d;
            score_q <= score_d;
            terr_q  <= terr_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign cmp_enable  = busy;
    assign cmp_start   = (state_q == S_ISSUE);
    assign done        = (state_q == S_DONE);
    assign notes_done  = notes_q;
    assign timeout_err = terr_q;

    note_score_accum #(
        .NOTE_W (NOTE_W),
        .TOT_W  (TOT_W)
    ) u_accum (
        .clk           (clk),
        .rst_n         (rst_n),
        .clr           (clr),
        .acc_en        (state_q == S_ACCUM),
        .score         (score_q),
        .total         (total_score),
        .perfect_count (perfect_count)
`ifdef NOTE_SCORE_STREAK_EN
        ,
        .best_streak   (best_streak)
`endif
    );

endmodule

// File: tb/tb_note_score_sequencer.sv
// Directed bench for note_score_sequencer: table of songs plus hand-written reset/timeout/stall/empty-song cases.
module tb_note_score_sequencer;

    localparam int NOTE_W = 8;
    localparam int TOT_W  = 12;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              song_start = 1'b0;
    logic [NOTE_W-1:0] song_len = '0;
    logic              pair_avail = 1'b1;
    logic              man_rdy = 1'b0;
    logic              mdl_rdy = 1'b0;
    logic [3:0]        mdl_score = 4'd0;
    logic              cmp_score_ready;
    logic [3:0]        cmp_score;

    logic              cmp_enable, cmp_start, busy, done, timeout_err;
    logic [NOTE_W-1:0] notes_done, perfect_count;
    logic [TOT_W-1:0]  total_score;
    logic              cmp_enable4, cmp_start4, busy4, done4, timeout_err4;
    logic [NOTE_W-1:0] notes_done4, perfect_count4;
    logic [3:0]        total_score4;
`ifdef NOTE_SCORE_STREAK_EN
    logic [NOTE_W-1:0] best_streak, best_streak4;
`endif

    assign cmp_score_ready = mdl_rdy | man_rdy;
    assign cmp_score       = man_rdy ? 4'd10 : mdl_score;

    note_score_sequencer #(.NOTE_W(NOTE_W), .TOT_W(TOT_W), .TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .song_start(song_start), .song_len(song_len),
        .pair_avail(pair_avail), .cmp_enable(cmp_enable), .cmp_start(cmp_start),
        .cmp_score_ready(cmp_score_ready), .cmp_score(cmp_score), .busy(busy), .done(done),
        .notes_done(notes_done), .total_score(total_score), .perfect_count(perfect_count),
        .timeout_err(timeout_err)
`ifdef NOTE_SCORE_STREAK_EN
        , .best_streak(best_streak)
`endif
    );

    note_score_sequencer #(.NOTE_W(NOTE_W), .TOT_W(4), .TIMEOUT(16)) dut4 (
        .clk(clk), .rst_n(rst_n), .song_start(song_start), .song_len(song_len),
        .pair_avail(pair_avail), .cmp_enable(cmp_enable4), .cmp_start(cmp_start4),
        .cmp_score_ready(cmp_score_ready), .cmp_score(cmp_score), .busy(busy4), .done(done4),
        .notes_done(notes_done4), .total_score(total_score4), .perfect_count(perfect_count4),
        .timeout_err(timeout_err4)
`ifdef NOTE_SCORE_STREAK_EN
        , .best_streak(best_streak4)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Comparator model: 4-cycle latency, response -1 means the comparator never answers.
    int resp [8];
    int pend = -1;
    int lat_cnt = 0;
    int start_cnt = 0;
    int song_base = 0;

    always @(negedge clk) begin
        int idx;
        mdl_rdy <= 1'b0;
        if (lat_cnt == 1 && pend >= 0) begin
            mdl_rdy   <= 1'b1;
            mdl_score <= pend[3:0];
        end
        if (lat_cnt != 0) lat_cnt <= lat_cnt - 1;
        if (cmp_start) begin
            idx       = start_cnt - song_base;
            pend      <= (idx >= 0 && idx < 8) ? resp[idx] : -1;
            start_cnt <= start_cnt + 1;
            lat_cnt   <= 4;
        end
    end

    typedef struct {
        int len;
        int sc [4];
        int tot;
        int perf;
        int terr;
        int tot4;
        int streak;
    } vec_t;

    vec_t vecs [6];

    task automatic set_resp(input int a, input int b, input int c, input int d);
        resp[0] = a; resp[1] = b; resp[2] = c; resp[3] = d;
        for (int i = 4; i < 8; i++) resp[i] = -1;
    endtask

    task automatic start_song(input int len);
        @(negedge clk);
        song_base  = start_cnt;
        song_len   = NOTE_W'(len);
        song_start = 1'b1;
        @(negedge clk);
        song_start = 1'b0;
    endtask

    task automatic wait_done(output int dcnt);
        int after;
        dcnt  = 0;
        after = 0;
        for (int i = 0; i < 800; i++) begin
            if (done) dcnt++;
            if (dcnt > 0) after++;
            if (after >= 5) break;
            @(negedge clk);
        end
    endtask

    task automatic wait_starts(input int n, output int seen);
        seen = 0;
        for (int i = 0; i < 300; i++) begin
            if (cmp_start) seen++;
            if (seen >= n) break;
            @(negedge clk);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1);
    end

    initial begin
        int d, seen, extra;

        vecs[0] = '{len:3, sc:'{10, 7, 0, 0},   tot:17, perf:1, terr:0, tot4:15, streak:1};
        vecs[1] = '{len:2, sc:'{10, 10, 0, 0},  tot:20, perf:2, terr:0, tot4:15, streak:2};
        vecs[2] = '{len:4, sc:'{10, 10, 0, 10}, tot:30, perf:3, terr:0, tot4:15, streak:2};
        vecs[3] = '{len:3, sc:'{5, 5, 3, 0},    tot:13, perf:0, terr:0, tot4:13, streak:0};
        vecs[4] = '{len:2, sc:'{10, -1, 0, 0},  tot:10, perf:1, terr:1, tot4:10, streak:1};
        vecs[5] = '{len:1, sc:'{7, 0, 0, 0},    tot:7,  perf:0, terr:0, tot4:7,  streak:0};
        set_resp(-1, -1, -1, -1);

        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cmp_start", cmp_start, 0);
        chk("rst_cmp_enable", cmp_enable, 0);
        chk("rst_total", total_score, 0);
        chk("rst_notes", notes_done, 0);
        chk("rst_perfect", perfect_count, 0);
        chk("rst_timeout", timeout_err, 0);
        rst_n = 1'b1;

        // Reset in WAIT_SCORE of the second note, after the first note has been accumulated.
        set_resp(10, 10, 10, -1);
        start_song(3);
        wait_starts(2, seen);
        chk("mid_starts_seen", seen, 2);
        repeat (2) @(negedge clk);
        chk("mid_pre_total", total_score, 10);
        chk("mid_pre_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_total", total_score, 0);
        chk("mid_rst_notes", notes_done, 0);
        chk("mid_rst_perfect", perfect_count, 0);
        chk("mid_rst_enable", cmp_enable, 0);
`ifdef NOTE_SCORE_STREAK_EN
        chk("mid_rst_streak", best_streak, 0);
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("mid_stray_busy", busy, 0);
        chk("mid_stray_total", total_score, 0);

        for (int v = 0; v < 6; v++) begin
            set_resp(vecs[v].sc[0], vecs[v].sc[1], vecs[v].sc[2], vecs[v].sc[3]);
            start_song(vecs[v].len);
            wait_done(d);
            chk($sformatf("v%0d_done_pulses", v), d, 1);
            chk($sformatf("v%0d_total", v), total_score, vecs[v].tot);
            chk($sformatf("v%0d_perfect", v), perfect_count, vecs[v].perf);
            chk($sformatf("v%0d_notes", v), notes_done, vecs[v].len);
            chk($sformatf("v%0d_timeout", v), timeout_err, vecs[v].terr);
            chk($sformatf("v%0d_total_sat4", v), total_score4, vecs[v].tot4);
            chk($sformatf("v%0d_starts", v), start_cnt - song_base, vecs[v].len);
            chk($sformatf("v%0d_busy", v), busy, 0);
`ifdef NOTE_SCORE_STREAK_EN
            chk($sformatf("v%0d_streak", v), best_streak, vecs[v].streak);
`endif
        end

        // Watchdog: second note hangs; a late strobe in WAIT_PAIR must not count.
        set_resp(10, -1, 5, -1);
        start_song(3);
        wait_starts(2, seen);
        chk("to_starts_seen", seen, 2);
        repeat (15) @(negedge clk);
        chk("to_early_err", timeout_err, 0);
        chk("to_early_total", total_score, 10);
        repeat (2) @(negedge clk);
        chk("to_err_set", timeout_err, 1);
        pair_avail = 1'b0;
        @(negedge clk);
        chk("to_notes_after", notes_done, 2);
        chk("to_total_after", total_score, 10);
        man_rdy = 1'b1;
        @(negedge clk);
        man_rdy = 1'b0;
        repeat (3) @(negedge clk);
        chk("late_notes", notes_done, 2);
        chk("late_total", total_score, 10);
        chk("late_starts", start_cnt - song_base, 2);
        pair_avail = 1'b1;
        wait_done(d);
        chk("to_done_pulses", d, 1);
        chk("to_final_total", total_score, 15);
        chk("to_final_err", timeout_err, 1);
        chk("to_final_notes", notes_done, 3);

        // pair_avail low for 50 cycles after the first note has issued.
        set_resp(7, 7, -1, -1);
        start_song(2);
        wait_starts(1, seen);
        chk("stall_first_start", seen, 1);
        pair_avail = 1'b0;
        extra = 0;
        repeat (50) begin
            @(negedge clk);
            if (cmp_start) extra++;
        end
        chk("stall_no_start", extra, 0);
        chk("stall_no_timeout", timeout_err, 0);
        chk("stall_busy", busy, 1);
        chk("stall_notes", notes_done, 1);
        chk("stall_total", total_score, 7);
        pair_avail = 1'b1;
        wait_done(d);
        chk("stall_done_pulses", d, 1);
        chk("stall_total_final", total_score, 14);
        chk("stall_timeout_final", timeout_err, 0);

        // Empty song, with a second song_start while still busy.
        start_song(0);
        chk("len0_done", done, 1);
        chk("len0_busy", busy, 1);
        chk("len0_total", total_score, 0);
        chk("len0_notes", notes_done, 0);
        song_len   = NOTE_W'(5);
        song_start = 1'b1;
        @(negedge clk);
        song_start = 1'b0;
        chk("len0_done_once", done, 0);
        extra = 0;
        seen  = 0;
        repeat (8) begin
            @(negedge clk);
            if (cmp_start) extra++;
            if (busy) seen++;
        end
        chk("len0_ignored_starts", extra, 0);
        chk("len0_ignored_busy", seen, 0);
        chk("len0_final_notes", notes_done, 0);
        chk("len0_final_perfect", perfect_count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
